// File: rtl/rx_organizer_ctrl.sv
// ---------------------------------------------------------------------------
// rx_organizer_ctrl
//
// Sequencer in front of the 20-bank receive sample organizer. It registers
// incoming ADC samples and emits the per-sample write trigger together with
// the bank index being written. Once every bank holds a full window it launches
// one read sweep per completed group of NUM_BANKS samples, and it raises a
// sticky overrun flag when a group completes while a sweep is still running.
//
// Ports
//   crx_clk           system clock
//   rrx_rst           synchronous, active-high reset
//   erx_en            global enable; low freezes all sequencing
//   idata_in          signed input sample
//   idata_valid       idata_in valid this cycle
//   odata_to_ram      registered sample to the organizer data input
//   onew_sample_trig  one-cycle write trigger to the organizer
//   obank_sel         bank receiving the current trigger
//   oprimed           all banks filled once (sticky)
//   osweep_start      one-cycle pulse on the first sweep cycle
//   osweep_active     high while a sweep is running
//   osweep_addr       sweep index, 0..MEMORY_LENGTH-1
//   osweep_last       high on the final sweep cycle
//   ooverrun          sticky overrun flag
//
// Optional build macro RX_ORG_CTRL_STATS_EN adds:
//   osweep_count      completed sweeps, saturating at 0xFFFF
//   odrop_count       dropped group completions, saturating at 0xFFFF
//
// States
//   S_FILL  | banks not yet filled once; waiting for primed
//   S_IDLE  | primed, waiting for a group completion
//   S_SWEEP | read sweep running, osweep_addr advancing
// ---------------------------------------------------------------------------
module rx_organizer_ctrl #(
    parameter int NUM_BANKS     = 20,
    parameter int MEMORY_LENGTH = 510,
    parameter int BANK_W        = 5,
    parameter int ADDR_W        = 9
) (
    input  logic                     crx_clk,
    input  logic                     rrx_rst,
    input  logic                     erx_en,
    input  logic signed [15:0]       idata_in,
    input  logic                     idata_valid,
    output logic signed [15:0]       odata_to_ram,
    output logic                     onew_sample_trig,
    output logic [BANK_W-1:0]        obank_sel,
    output logic                     oprimed,
    output logic                     osweep_start,
    output logic                     osweep_active,
    output logic [ADDR_W-1:0]        osweep_addr,
    output logic                     osweep_last,
    output logic                     ooverrun
`ifdef RX_ORG_CTRL_STATS_EN
    ,
    output logic [15:0]              osweep_count,
    output logic [15:0]              odrop_count
`endif
);

    localparam int FILL_MAX = NUM_BANKS * MEMORY_LENGTH;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEMORY_LENGTH - 1);
    localparam logic [FILL_W-1:0] FILL_TOP  = FILL_W'(FILL_MAX);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_MAX - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_IDLE  = 2'd1,
        S_SWEEP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                start_q, start_d;
    logic                overrun_q, overrun_d;

    logic signed [15:0]  data_q;
    logic                trig_q;
    logic [BANK_W-1:0]   bank_q;
    logic [FILL_W-1:0]   fill_q;
    logic                primed_q;

    logic                accept;
    logic                completion;
    logic                prime_now;
    logic                sweep_end;

    assign accept     = idata_valid & erx_en;
    // A group completes on the trigger that writes the last bank.
    assign completion = trig_q && (bank_q == BANK_LAST);
    // fill_q hits FILL_LAST exactly once per fill, so this fires only once.
    assign prime_now  = trig_q && (fill_q == FILL_LAST);
    assign sweep_end  = (state_q == S_SWEEP) && (addr_q == ADDR_LAST);

    // Write path and fill tracking. Every register holds while erx_en is low,
    // so a pending trigger is deferred rather than lost.
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            data_q   <= '0;
            trig_q   <= 1'b0;
            bank_q   <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
        end else if (erx_en) begin
            trig_q <= accept;
            if (accept) begin
                data_q <= idata_in;
            end
            if (trig_q) begin
                bank_q <= (bank_q == BANK_LAST) ? '0 : bank_q + BANK_W'(1);
                if (fill_q != FILL_TOP) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end
            if (prime_now) begin
                primed_q <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state_q   <= S_FILL;
            addr_q    <= '0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (erx_en) begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            start_q   <= start_d;
            overrun_q <= overrun_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_d   = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            S_FILL: begin
                if (prime_now) begin
                    if (completion) begin
                        state_d = S_SWEEP;
                        start_d = 1'b1;
                        addr_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (completion) begin
                    state_d = S_SWEEP;
                    start_d = 1'b1;
                    addr_d  = '0;
                end
            end
            S_SWEEP: begin
                if (sweep_end) begin
                    addr_d = '0;
                    // Completion on the last cycle chains a new sweep with no gap.
                    if (completion) begin
                        state_d = S_SWEEP;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    // Completion mid-sweep is dropped, not queued.
                    if (completion) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
                addr_d  = '0;
            end
        endcase
    end

    // FSM outputs; pulses are masked while frozen
    always_comb begin
        onew_sample_trig = trig_q & erx_en;
        osweep_start     = start_q & erx_en;
        osweep_active    = (state_q == S_SWEEP);
        osweep_addr      = addr_q;
        osweep_last      = sweep_end & erx_en;
    end

    assign odata_to_ram = data_q;
    assign obank_sel    = bank_q;
    assign oprimed      = primed_q;
    assign ooverrun     = overrun_q;

`ifdef RX_ORG_CTRL_STATS_EN
    logic [15:0] sweep_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            sweep_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (erx_en) begin
            if (sweep_end && (sweep_cnt_q != 16'hFFFF)) begin
                sweep_cnt_q <= sweep_cnt_q + 16'd1;
            end
            if ((state_q == S_SWEEP) && !sweep_end && completion &&
                (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign osweep_count = sweep_cnt_q;
    assign odrop_count  = drop_cnt_q;
`endif

endmodule
